// File: rtl/aon_clkdiv_ctrl.sv
// Run-time controller for the AON slow clock: programmable half-period divider whose
// start, stop and ratio changes are all deferred to a falling boundary so no runt pulse escapes.
module aon_clkdiv_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_req_i,
    output logic             div_ack_o,
    output logic             clk_out_o,
    output logic             rise_tick_o,
    output logic             fall_tick_o,
    output logic             running_o,
    output logic [CNT_W-1:0] div_cur_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] DEFAULT_DIV_L = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk;
    logic             r_rise;
    logic             r_fall;
    logic             r_ack;
    logic             r_running;

    logic [CNT_W-1:0] w_div_clamped;
    logic             w_terminal;
    logic             w_fall_bound;
    logic             w_accept;

    assign w_div_clamped = (div_i == '0) ? ONE : div_i;
    assign w_terminal    = (r_cnt == (r_div_cur - ONE));
    assign w_fall_bound  = w_terminal && r_clk;
    // The ack cycle blocks acceptance so a request still held high is not taken twice.
    assign w_accept      = div_req_i && !r_pend_vld && !r_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div_cur  <= DEFAULT_DIV_L;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clk      <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_ack      <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (w_accept) begin
                        r_div_cur <= w_div_clamped;
                        r_ack     <= 1'b1;
                    end
                    if (en_i) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (w_accept) begin
                        r_pend     <= w_div_clamped;
                        r_pend_vld <= 1'b1;
                    end
                    if (w_terminal) begin
                        r_cnt  <= '0;
                        r_clk  <= !r_clk;
                        r_rise <= !r_clk;
                        r_fall <= r_clk;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                    // Ratio changes and halting only happen here, after a complete high phase.
                    if (w_fall_bound) begin
                        if (r_pend_vld) begin
                            r_div_cur  <= r_pend;
                            r_pend_vld <= 1'b0;
                            r_ack      <= 1'b1;
                        end
                        if (!en_i) begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                        end else begin
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= en_i ? RUN : STOP;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_clk     <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign div_ack_o   = r_ack;
    assign clk_out_o   = r_clk;
    assign rise_tick_o = r_rise;
    assign fall_tick_o = r_fall;
    assign running_o   = r_running;
    assign div_cur_o   = r_div_cur;

endmodule

// File: tb/tb_aon_clkdiv_ctrl.sv
// Scoreboarded bench for aon_clkdiv_ctrl: a phase-timeline model predicts every tick/ack
// event with its cycle number; a negedge monitor pops and compares each one the DUT emits.
module tb_aon_clkdiv_ctrl;

    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en_i;
    logic [CNT_W-1:0] div_i;
    logic             div_req_i;
    logic             div_ack_o;
    logic             clk_out_o;
    logic             rise_tick_o;
    logic             fall_tick_o;
    logic             running_o;
    logic [CNT_W-1:0] div_cur_o;

    aon_clkdiv_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_req_i   (div_req_i),
        .div_ack_o   (div_ack_o),
        .clk_out_o   (clk_out_o),
        .rise_tick_o (rise_tick_o),
        .fall_tick_o (fall_tick_o),
        .running_o   (running_o),
        .div_cur_o   (div_cur_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit ack;
        int div;
    } evt_t;

    evt_t expQ[$];
    evt_t monE;
    int   checkCount = 0;
    int   passCount  = 0;
    bit   monEn      = 1'b1;
    int   curDiv     = DEF_DIV;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic int clampDiv(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic bit enAt(input int e, input int k, input int fA, input int fB, input int sF);
        return (e > k) && !(e > fA && e <= fB) && (e <= sF);
    endfunction

    function automatic void pushEvt(input int c, input bit r, input bit f, input bit a, input int d);
        evt_t x;
        x.cyc = c; x.rise = r; x.fall = f; x.ack = a; x.div = d;
        expQ.push_back(x);
    endfunction

    // Every event the DUT emits must match the head of the expected queue exactly.
    always @(negedge clk) begin
        if (monEn && reset_n && (rise_tick_o || fall_tick_o || div_ack_o)) begin
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpectedEvent: got rise=%0b fall=%0b ack=%0b at cycle %0d, required none",
                         rise_tick_o, fall_tick_o, div_ack_o, cyc);
            end else begin
                monE = expQ.pop_front();
                if (monE.cyc == cyc && monE.rise == rise_tick_o && monE.fall == fall_tick_o &&
                    monE.ack == div_ack_o && monE.div == int'(div_cur_o) && clk_out_o == monE.rise)
                    passCount++;
                else
                    $display("[TB] FAIL event: got cyc=%0d rfa=%0b%0b%0b clk=%0b div=%0d, required cyc=%0d rfa=%0b%0b%0b clk=%0b div=%0d",
                             cyc, rise_tick_o, fall_tick_o, div_ack_o, clk_out_o, div_cur_o,
                             monE.cyc, monE.rise, monE.fall, monE.ack, monE.rise, monE.div);
            end
        end
    end

    // Timeline model: the clock toggles every d edges starting d edges after RUN entry;
    // a pending change lands on the first fall at least two edges after the request,
    // and the run halts on the first fall at which enable is sampled low.
    task automatic buildSegment(input int k, input int d0, input bit hasReq, input int r,
                                input int dNew, input int nStop, input bit flicker, input int g,
                                input int extra, output int fA, output int fB, output int sF,
                                output int lastEdge, output int newDiv);
        int  edgeN, d, riseCount, gg;
        bit  level, pendDone, ackNow;
        d = d0; level = 1'b0; pendDone = !hasReq; riseCount = 0;
        fA = 0; fB = 0; sF = 1 << 30; lastEdge = 0;
        edgeN = k + 1 + d;
        for (int guard = 0; guard < 200; guard++) begin
            level = !level;
            if (level) begin
                riseCount++;
                pushEvt(edgeN, 1'b1, 1'b0, 1'b0, d);
                if (riseCount == nStop) begin
                    if (flicker && d >= 2) begin
                        gg = (g > d - 1) ? d - 1 : g;
                        fA = edgeN; fB = edgeN + gg; sF = fB + 1 + extra;
                    end else begin
                        sF = edgeN + extra;
                    end
                end
            end else begin
                ackNow = !pendDone && (edgeN >= r + 2);
                if (ackNow) begin
                    d = clampDiv(dNew);
                    pendDone = 1'b1;
                end
                pushEvt(edgeN, 1'b0, 1'b1, ackNow, d);
                if (edgeN > sF) begin
                    lastEdge = edgeN;
                    break;
                end
            end
            edgeN += d;
        end
        newDiv = d;
    endtask

    task automatic idleReconfig(input int d);
        div_i = CNT_W'(d);
        div_req_i = 1'b1;
        pushEvt(cyc + 1, 1'b0, 1'b0, 1'b1, clampDiv(d));
        curDiv = clampDiv(d);
        @(posedge clk); #1;
        div_req_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic runSegment(input bit hasReq, input int dNew, input int rOff, input int nStop,
                              input bit flicker, input int g, input int extra);
        int k, r, fA, fB, sF, lastEdge, newDiv, e;
        k = cyc;
        r = k + rOff;
        buildSegment(k, curDiv, hasReq, r, dNew, nStop, flicker, g, extra,
                     fA, fB, sF, lastEdge, newDiv);
        while (cyc < lastEdge + 2) begin
            e = cyc;
            en_i = enAt(e + 1, k, fA, fB, sF);
            if (hasReq && e == r) begin
                div_i = CNT_W'(dNew);
                div_req_i = 1'b1;
            end else if (div_ack_o) begin
                div_req_i = 1'b0;
            end else if (div_req_i) begin
                div_i = CNT_W'($urandom_range(0, 50));
            end
            @(posedge clk); #1;
        end
        div_req_i = 1'b0;
        curDiv = newDiv;
        checkOutput("stoppedRunning", running_o, 0);
        checkOutput("stoppedClkLow", clk_out_o, 0);
        checkOutput("stoppedDivCur", div_cur_o, curDiv);
        checkOutput("segmentQueueEmpty", expQ.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int d);
        idleReconfig(d);
        runSegment(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(1, curDiv),
                   $urandom_range(1, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
                   $urandom_range(0, 2 * curDiv));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit quiet;
        reset_n = 1'b0; en_i = 1'b0; div_req_i = 1'b0; div_i = '0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        checkOutput("resetClk", clk_out_o, 0);
        checkOutput("resetRunning", running_o, 0);
        checkOutput("resetDivCur", div_cur_o, DEF_DIV);
        checkOutput("resetAck", div_ack_o, 0);
        checkOutput("resetTicks", {rise_tick_o, fall_tick_o}, 0);
        @(posedge clk); #1;

        // Default ratio, plain start and stop.
        runSegment(1'b0, 0, 1, 2, 1'b0, 1, 0);
        // Zero clamps to one; then a mid-run change to two.
        idleReconfig(0);
        runSegment(1'b0, 0, 1, 3, 1'b0, 1, 0);
        idleReconfig(4);
        runSegment(1'b1, 2, 3, 3, 1'b0, 1, 2);
        // Enable and request dropping together with a stop flicker beforehand.
        idleReconfig(4);
        runSegment(1'b1, 6, 1, 2, 1'b1, 2, 0);

        for (int i = 0; i < 20; i++) applyStimulus($urandom_range(0, 6));

        // Reset in the middle of a high phase with a change pending.
        idleReconfig(5);
        monEn = 1'b0;
        en_i = 1'b1;
        for (int i = 0; i < 50 && !rise_tick_o; i++) begin @(posedge clk); #1; end
        checkOutput("riseBeforeReset", rise_tick_o, 1);
        div_i = CNT_W'(6);
        div_req_i = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midResetClk", clk_out_o, 0);
        checkOutput("midResetRunning", running_o, 0);
        checkOutput("midResetAck", div_ack_o, 0);
        checkOutput("midResetDivCur", div_cur_o, DEF_DIV);
        reset_n = 1'b1; en_i = 1'b0; div_req_i = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (div_ack_o || clk_out_o || running_o) quiet = 1'b0;
        end
        checkOutput("postResetQuiet", quiet, 1);
        curDiv = DEF_DIV;
        monEn = 1'b1;

        runSegment(1'b1, 3, 2, 2, 1'b0, 1, 1);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
